pipelined_addsub: RTL and testbench

- Parametrised successor to the 32-bit combinational adder: a carry-segmented, pipelined two's-complement adder/subtractor.
- Adds a per-operation add/sub mode, optional saturation, full status flags (carry, signed overflow, zero) and valid/ready flow control with per-stage bubble collapse.
- Sits between operand producers (e.g. Wallace-tree partial-product reduction) and the result consumer, where a single-cycle WIDTH-bit carry chain would limit the clock.

---
 rtl/pipelined_addsub_if.sv | 48 ++++
 rtl/pipelined_addsub.sv | 155 +++++++++++++++
 tb/tb_pipelined_addsub.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// The master side produces operands and consumes results; the slave side is the adder.
interface pipelined_addsub_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             sat_en;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;
   logic             zero;

   modport master (
      output in_valid,
      input  in_ready,
      output a,
      output b,
      output sub,
      output sat_en,
      input  out_valid,
      output out_ready,
      input  result,
      input  carry_out,
      input  overflow,
      input  zero
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  a,
      input  b,
      input  sub,
      input  sat_en,
      output out_valid,
      input  out_ready,
      output result,
      output carry_out,
      output overflow,
      output zero
   );
endinterface

// File: rtl/pipelined_addsub.sv
// Carry-segmented pipelined add/sub with saturation, status flags and
// valid/ready flow control; one SEG-bit carry segment per stage.
module pipelined_addsub #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input logic               clk,
   input logic               rst_n,
   pipelined_addsub_if.slave bus
);
   localparam int unsigned SEG = WIDTH / STAGES;

   logic [STAGES-1:0] valid_d;
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] adv;
   logic              last_v;

   logic [WIDTH-1:0]  result_d;
   logic [WIDTH-1:0]  result_q;
   logic              carry_d;
   logic              carry_q;
   logic              overflow_d;
   logic              overflow_q;
   logic              zero_d;
   logic              zero_q;

   // A stage may move on when any stage at or beyond it holds a bubble,
   // or the consumer takes the head beat.
   always_comb begin
      logic full;
      adv  = '0;
      full = 1'b1;
      for (int k = STAGES - 1; k >= 0; k--) begin
         full   = full & valid_q[k];
         adv[k] = bus.out_ready | ~full;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned BIN_W = WIDTH - k * SEG;

      logic [WIDTH-1:0] w_i;
      logic [BIN_W-1:0] b_i;
      logic             c_i;
      logic             s_i;
      logic             v_i;
      logic [SEG:0]     seg_sum;

      if (k == 0) begin : g_head
         assign w_i = bus.a;
         assign b_i = bus.sub ? ~bus.b : bus.b;
         assign c_i = bus.sub;
         assign s_i = bus.sat_en;
         assign v_i = bus.in_valid;
      end else begin : g_link
         assign w_i = g_stage[k-1].g_mid.w_q;
         assign b_i = g_stage[k-1].g_mid.b_q;
         assign c_i = g_stage[k-1].g_mid.c_q;
         assign s_i = g_stage[k-1].g_mid.s_q;
         assign v_i = valid_q[k-1];
      end

      assign seg_sum = {1'b0, w_i[k*SEG +: SEG]}
                     + {1'b0, b_i[SEG-1:0]}
                     + {{SEG{1'b0}}, c_i};

      assign valid_d[k] = adv[k] ? v_i : valid_q[k];

      if (k < STAGES - 1) begin : g_mid
         localparam int unsigned BO_W = BIN_W - SEG;

         // w holds finished sum bits below the next segment and raw A above.
         logic [WIDTH-1:0] w_d;
         logic [WIDTH-1:0] w_q;
         logic [BO_W-1:0]  b_d;
         logic [BO_W-1:0]  b_q;
         logic             c_d;
         logic             c_q;
         logic             s_d;
         logic             s_q;

         always_comb begin
            w_d                = w_i;
            w_d[k*SEG +: SEG]  = seg_sum[SEG-1:0];
            b_d                = b_i[BIN_W-1:SEG];
            c_d                = seg_sum[SEG];
            s_d                = s_i;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               w_q <= '0;
               b_q <= '0;
               c_q <= 1'b0;
               s_q <= 1'b0;
            end else if (adv[k] && v_i) begin
               w_q <= w_d;
               b_q <= b_d;
               c_q <= c_d;
               s_q <= s_d;
            end
         end
      end else begin : g_last
         logic [WIDTH-1:0] raw;
         logic             a_msb;
         logic             b_msb;
         logic             ovf;

         always_comb begin
            raw                  = w_i;
            raw[WIDTH-1 -: SEG]  = seg_sum[SEG-1:0];
            a_msb                = w_i[WIDTH-1];
            b_msb                = b_i[SEG-1];
            ovf                  = (a_msb == b_msb)
                                 && (raw[WIDTH-1] != a_msb);
            result_d             = raw;
            if (s_i && ovf) begin
               result_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
            end
            carry_d              = seg_sum[SEG];
            overflow_d           = ovf;
            zero_d               = ~|result_d;
         end

         assign last_v = v_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= '0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (adv[STAGES-1] && last_v) begin
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
         end
      end
   end

   assign bus.in_ready  = adv[0];
   assign bus.out_valid = valid_q[STAGES-1];
   assign bus.result    = result_q;
   assign bus.carry_out = carry_q;
   assign bus.overflow  = overflow_q;
   assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed corner cases plus
// randomized streams against an arithmetic reference model and a FIFO.
module tb_pipelined_addsub;
   localparam int W = 32;
   localparam int S = 4;

   typedef struct {
      logic [W-1:0] res;
      logic         c;
      logic         o;
      logic         z;
      int           acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   pipelined_addsub_if #(.WIDTH(W)) bus ();

   pipelined_addsub #(
      .WIDTH (W),
      .STAGES(S)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc_n = 0;
   bit   lat_chk = 1'b0;
   bit   acc = 1'b0;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: true signed/unsigned arithmetic on wide integers.
   function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                  logic sub, logic sat);
      exp_t e;
      longint sa, sb, sr;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sr = sub ? sa - sb : sa + sb;
      ua = {32'd0, a};
      ub = {32'd0, b};
      e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      e.c = sub ? (ua >= ub) : (((ua + ub) >> 32) != 0);
      e.res = sub ? a - b : a + b;
      if (sat && e.o) e.res = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      e.z = (e.res == '0);
      e.acc = 0;
      return e;
   endfunction

   task automatic cyc();
      exp_t e;
      @(negedge clk);
      cyc_n++;
      acc = 1'b0;
      chk("in_ready", 64'(bus.in_ready),
          64'(bus.out_ready || (q.size() < S)));
      if (bus.out_valid) begin
         if (q.size() == 0) begin
            chk("stale_beat", 64'(bus.out_valid), 64'(0));
         end else if (bus.out_ready) begin
            e = q.pop_front();
            chk("result", 64'(bus.result), 64'(e.res));
            chk("carry", 64'(bus.carry_out), 64'(e.c));
            chk("overflow", 64'(bus.overflow), 64'(e.o));
            chk("zero", 64'(bus.zero), 64'(e.z));
            if (lat_chk) chk("latency", 64'(cyc_n - e.acc), 64'(S));
         end else begin
            chk("hold", 64'(bus.result), 64'(q[0].res));
         end
      end
      if (bus.in_valid && bus.in_ready) begin
         e = model(bus.a, bus.b, bus.sub, bus.sat_en);
         e.acc = cyc_n;
         q.push_back(e);
         acc = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(logic [W-1:0] a, logic [W-1:0] b,
                       logic s, logic sat);
      bus.a = a;
      bus.b = b;
      bus.sub = s;
      bus.sat_en = sat;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         cyc();
         if (acc) break;
      end
      if (!acc) chk("accept_timeout", 64'(acc), 64'(1));
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && q.size() > 0; i++) cyc();
      if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'(0));
      cyc();
      cyc();
   endtask

   task automatic directed(string tag, logic [W-1:0] a, logic [W-1:0] b,
                           logic s, logic sat, logic [W-1:0] r,
                           logic c, logic o, logic z);
      send(a, b, s, sat);
      drain();
      chk({tag, "_res"}, 64'(bus.result), 64'(r));
      chk({tag, "_c"}, 64'(bus.carry_out), 64'(c));
      chk({tag, "_o"}, 64'(bus.overflow), 64'(o));
      chk({tag, "_z"}, 64'(bus.zero), 64'(z));
   endtask

   task automatic stream(int nbeats, bit ramp);
      int nb;
      nb = 0;
      bus.in_valid = 1'b0;
      for (int t = 0; t < 20 * nbeats + 100 && nb < nbeats; t++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         if (!bus.in_valid && $urandom_range(0, 2) != 0) begin
            bus.a = ramp ? W'(nb) : W'($urandom());
            bus.b = ramp ? W'(nb) : W'($urandom());
            bus.sub = ramp ? 1'b0 : 1'($urandom_range(0, 1));
            bus.sat_en = ramp ? 1'b0 : 1'($urandom_range(0, 1));
            bus.in_valid = 1'b1;
         end
         cyc();
         if (acc) begin
            nb++;
            bus.in_valid = 1'b0;
         end
      end
      bus.in_valid = 1'b0;
      chk("stream_count", 64'(nb), 64'(nbeats));
      bus.out_ready = 1'b1;
      drain();
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.sub = 1'b0;
      bus.sat_en = 1'b0;
      bus.out_ready = 1'b1;
      #2 rst_n = 1'b0;
      #20;
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_result", 64'(bus.result), 64'(0));
      chk("rst_flags", 64'({bus.carry_out, bus.overflow, bus.zero}), 64'(0));
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

      lat_chk = 1'b1;
      directed("add", 32'h5, 32'h3, 1'b0, 1'b0, 32'h8, 1'b0, 1'b0, 1'b0);
      directed("carry", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0,
               32'h0, 1'b1, 1'b0, 1'b1);
      directed("ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
               32'h8000_0000, 1'b0, 1'b1, 1'b0);
      directed("satp", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1,
               32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
      directed("satn", 32'h8000_0000, 32'h1, 1'b1, 1'b1,
               32'h8000_0000, 1'b1, 1'b1, 1'b0);
      directed("borrow", 32'h3, 32'h5, 1'b1, 1'b0,
               32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      directed("noborrow", 32'h5, 32'h3, 1'b1, 1'b0,
               32'h2, 1'b1, 1'b0, 1'b0);

      // Fill the pipe against a stalled consumer.
      lat_chk = 1'b0;
      bus.out_ready = 1'b0;
      bus.sub = 1'b0;
      bus.sat_en = 1'b0;
      bus.a = 32'd100;
      bus.b = 32'd1;
      bus.in_valid = 1'b1;
      for (int t = 0; t < 8; t++) begin
         cyc();
         if (acc) bus.a = bus.a + 32'd1;
      end
      bus.in_valid = 1'b0;
      chk("full_count", 64'(q.size()), 64'(S));
      chk("full_in_ready", 64'(bus.in_ready), 64'(0));
      bus.out_ready = 1'b1;
      drain();

      stream(8, 1'b1);
      stream(200, 1'b0);

      // Reset with three beats in flight.
      lat_chk = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.a = W'(32'h1000 + i);
         bus.b = W'(i);
         bus.in_valid = 1'b1;
         cyc();
      end
      bus.in_valid = 1'b0;
      chk("inflight", 64'(q.size()), 64'(3));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_out_valid", 64'(bus.out_valid), 64'(0));
      chk("mid_result", 64'(bus.result), 64'(0));
      chk("mid_flags", 64'({bus.carry_out, bus.overflow, bus.zero}), 64'(0));
      q.delete();
      #10 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) cyc();
      directed("post", 32'h10, 32'h20, 1'b0, 1'b0,
               32'h30, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
